fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generator with a one-cycle memory,
// an output register plus a one-entry skid buffer, redirects and a sticky misalignment trap.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter bit          CHECK_ALIGN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {BOOT, RUN, ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        err_q, err_d;

  logic        consume;
  logic [1:0]  occupancy;
  logic        misaligned;

  assign imem_addr    = pc_q;
  assign if_valid     = out_valid_q;
  assign if_inst      = out_inst_q;
  assign if_pc        = out_pc_q;
  assign misalign_err = err_q;

  assign consume    = out_valid_q & if_ready;
  // Entries that will still be held after this edge; a new request needs a free slot for its reply.
  assign occupancy  = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q} - {1'b0, consume};
  assign misaligned = CHECK_ALIGN && (redirect_target[1:0] != 2'b00);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    out_valid_d   = out_valid_q;
    out_inst_d    = out_inst_q;
    out_pc_d      = out_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_inst_d   = skid_inst_q;
    skid_pc_d     = skid_pc_q;
    err_d         = err_q;
    imem_req      = 1'b0;

    if (state_q != ERR) begin
      if (redirect_valid) begin
        out_valid_d  = 1'b0;
        skid_valid_d = 1'b0;
        if (misaligned) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          state_d = RUN;
          pc_d    = redirect_target;
        end
      end else begin
        state_d = RUN;
        if (state_q == RUN && occupancy < 2'd2) begin
          imem_req      = 1'b1;
          pc_d          = pc_q + 32'd4;
          inflight_d    = 1'b1;
          inflight_pc_d = pc_q;
        end

        if (!out_valid_q || consume) begin
          if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_inst_d   = skid_inst_q;
            out_pc_d     = skid_pc_q;
            skid_valid_d = inflight_q;
            if (inflight_q) begin
              skid_inst_d = imem_rdata;
              skid_pc_d   = inflight_pc_q;
            end
          end else begin
            out_valid_d = inflight_q;
            if (inflight_q) begin
              out_inst_d = imem_rdata;
              out_pc_d   = inflight_pc_q;
            end
          end
        end else if (inflight_q) begin
          // Output stalled: the reply parks in the skid slot, which the occupancy rule keeps free.
          skid_valid_d = 1'b1;
          skid_inst_d  = imem_rdata;
          skid_pc_d    = inflight_pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      out_valid_q   <= 1'b0;
      out_inst_q    <= 32'd0;
      out_pc_q      <= 32'd0;
      skid_valid_q  <= 1'b0;
      skid_inst_q   <= 32'd0;
      skid_pc_q     <= 32'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      out_valid_q   <= out_valid_d;
      out_inst_q    <= out_inst_d;
      out_pc_q      <= out_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_inst_q   <= skid_inst_d;
      skid_pc_q     <= skid_pc_d;
      err_q         <= err_d;
    end
  end

endmodule
